// File: rtl/rv32m_pkg.sv
// +-----------------------------------------------------------------------------
// | rv32m_pkg : shared RV32M divide opcodes, divider FSM state type, helpers
// | Revision  : 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

package rv32m_pkg;

  localparam int XLEN = 32;

  localparam logic [4:0] ALU_DIV  = 5'b01000;
  localparam logic [4:0] ALU_DIVU = 5'b01001;
  localparam logic [4:0] ALU_REM  = 5'b01010;
  localparam logic [4:0] ALU_REMU = 5'b01011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // All four divide codes share the 010xx prefix.
  function automatic logic is_div_op(input logic [4:0] sel);
    return sel[4:2] == 3'b010;
  endfunction

endpackage

`default_nettype wire

// File: rtl/div_step.sv
// +-----------------------------------------------------------------------------
// | div_step : one combinational radix-2 restoring shift/subtract/restore step
// | Revision : 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

module div_step (
  input  logic [31:0] rem_i,
  input  logic [31:0] quo_i,
  input  logic [31:0] div_i,
  output logic [31:0] rem_o,
  output logic [31:0] quo_o
);

  logic [32:0] shifted;
  logic [32:0] diff;

  // The quotient register starts out holding the dividend; its MSB is shifted
  // into the partial remainder while the new quotient bit enters at the LSB.
  always_comb begin
    shifted = {rem_i, quo_i[31]};
    diff    = shifted - {1'b0, div_i};
    if (!diff[32]) begin
      rem_o = diff[31:0];
      quo_o = {quo_i[30:0], 1'b1};
    end else begin
      rem_o = shifted[31:0];
      quo_o = {quo_i[30:0], 1'b0};
    end
  end

endmodule

`default_nettype wire

// File: rtl/div_unit.sv
// +-----------------------------------------------------------------------------
// | div_unit : iterative 32-bit RV32M divider (DIV/DIVU/REM/REMU), 33-cycle
// |            latency; DIV_UNIT_EARLY_OUT_EN shortcuts div-by-zero/overflow.
// | Revision : 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

module div_unit
  import rv32m_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       alu_select,
  input  logic [31:0]      operand_a,
  input  logic [31:0]      operand_b,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      result,
  output logic [TAG_W-1:0] tag_out,
  output logic             busy
);

  div_state_e       state_q, state_d;
  logic [5:0]       cnt_q, cnt_d;
  logic [31:0]      rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, a_raw_q, a_raw_d;
  logic             is_rem_q, is_rem_d, neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
  logic             div0_q, div0_d, ovf_q, ovf_d;
  logic [TAG_W-1:0] tag_q, tag_d, tag_out_q, tag_out_d;
  logic             out_valid_q, out_valid_d;
  logic [31:0]      result_q, result_d;

  logic [31:0] step_rem, step_quo;
  logic        accept, sgn, a_neg, b_neg;
  logic [31:0] final_val;

  div_step u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .div_i (dvs_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  assign in_ready  = (state_q == IDLE) && !flush;
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign tag_out   = tag_out_q;

  assign accept = in_valid && in_ready && is_div_op(alu_select);
  assign sgn    = !alu_select[0];
  assign a_neg  = sgn && operand_a[31];
  assign b_neg  = sgn && operand_b[31];

  // Special cases override the iterated magnitude so they are identical
  // whether or not the early-out shortcut skipped the iteration.
  always_comb begin
    final_val = '0;
    if (div0_q)
      final_val = is_rem_q ? a_raw_q : 32'hFFFF_FFFF;
    else if (ovf_q)
      final_val = is_rem_q ? 32'h0 : 32'h8000_0000;
    else if (is_rem_q)
      final_val = neg_rem_q ? -rem_q : rem_q;
    else
      final_val = neg_quo_q ? -quo_q : quo_q;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    a_raw_d   = a_raw_q;
    is_rem_d  = is_rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    ovf_d     = ovf_q;
    tag_d     = tag_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          rem_d     = '0;
          quo_d     = a_neg ? -operand_a : operand_a;
          dvs_d     = b_neg ? -operand_b : operand_b;
          a_raw_d   = operand_a;
          is_rem_d  = alu_select[1];
          neg_quo_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          div0_d    = (operand_b == 32'h0);
          ovf_d     = sgn && (operand_a == 32'h8000_0000) && (operand_b == 32'hFFFF_FFFF);
          tag_d     = tag_in;
          cnt_d     = '0;
`ifdef DIV_UNIT_EARLY_OUT_EN
          state_d   = ((operand_b == 32'h0) ||
                       (sgn && (operand_a == 32'h8000_0000) && (operand_b == 32'hFFFF_FFFF)))
                      ? DONE : CALC;
`else
          state_d   = CALC;
`endif
        end
      end
      CALC: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_valid_q && out_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered one cycle behind DONE entry and captured once.
    out_valid_d = (state_q == DONE) && !(out_valid_q && out_ready);
    result_d    = out_valid_d ? (out_valid_q ? result_q : final_val) : '0;
    tag_out_d   = out_valid_d ? (out_valid_q ? tag_out_q : tag_q) : '0;

    if (flush) begin
      state_d     = IDLE;
      cnt_d       = '0;
      out_valid_d = 1'b0;
      result_d    = '0;
      tag_out_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      a_raw_q     <= '0;
      is_rem_q    <= 1'b0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      div0_q      <= 1'b0;
      ovf_q       <= 1'b0;
      tag_q       <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      tag_out_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      a_raw_q     <= a_raw_d;
      is_rem_q    <= is_rem_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      div0_q      <= div0_d;
      ovf_q       <= ovf_d;
      tag_q       <= tag_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      tag_out_q   <= tag_out_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_div_unit.sv
// +-----------------------------------------------------------------------------
// | tb_div_unit : scoreboard bench for div_unit with directed vectors
// | Revision    : 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

module tb_div_unit;

  localparam int TAG_W = 5;
  localparam logic [4:0] OP_DIV  = 5'b01000;
  localparam logic [4:0] OP_DIVU = 5'b01001;
  localparam logic [4:0] OP_REM  = 5'b01010;
  localparam logic [4:0] OP_REMU = 5'b01011;
  localparam int LAT = 33;
`ifdef DIV_UNIT_EARLY_OUT_EN
  localparam int SPL = 1;
`else
  localparam int SPL = 33;
`endif

  logic             clk, rst_n, in_valid, in_ready, flush, out_valid, out_ready, busy;
  logic [4:0]       alu_select;
  logic [31:0]      operand_a, operand_b, result;
  logic [TAG_W-1:0] tag_in, tag_out;

  div_unit #(.TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_select (alu_select),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .tag_in     (tag_in),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .tag_out    (tag_out),
    .busy       (busy)
  );

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [31:0]      res;
    int               acc;
    int               lat;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  logic prev_v = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: checks every presented output against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_output: got tag %h result %h expected none", tag_out, result);
      end else begin
        chk("result", result, sb[0].res);
        chk("tag", 32'(tag_out), 32'(sb[0].tag));
        if (!prev_v) chk("latency", 32'(cyc - sb[0].acc), 32'(sb[0].lat));
        if (out_ready) void'(sb.pop_front());
      end
    end
    prev_v <= out_valid;
  end

  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [TAG_W-1:0] tg, input logic [31:0] res, input int lat,
                       input bit track);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("in_ready_before_issue", 32'(in_ready), 32'd1);
    in_valid   = 1'b1;
    alu_select = op;
    operand_a  = a;
    operand_b  = b;
    tag_in     = tg;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (track) sb.push_back('{tg, res, cyc, lat});
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic run(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [TAG_W-1:0] tg, input logic [31:0] res, input int lat);
    issue(op, a, b, tg, res, lat, 1'b1);
    wait_drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; in_valid = 1'b0; alu_select = '0; operand_a = '0; operand_b = '0;
    tag_in = '0; flush = 1'b0; out_ready = 1'b1;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_tag", 32'(tag_out), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_after_reset", 32'(in_ready), 32'd1);

    // Directed vectors
    run(OP_DIV,  32'd100,        32'd7,          5'd1,  32'd14,          LAT);
    run(OP_REM,  32'd100,        32'd7,          5'd2,  32'd2,           LAT);
    run(OP_DIV,  32'hFFFF_FFF9,  32'd2,          5'd3,  32'hFFFF_FFFD,   LAT);
    run(OP_REM,  32'hFFFF_FFF9,  32'd2,          5'd4,  32'hFFFF_FFFF,   LAT);
    run(OP_DIVU, 32'hFFFF_FFF9,  32'd2,          5'd5,  32'h7FFF_FFFC,   LAT);
    run(OP_DIV,  32'd7,          32'hFFFF_FFFE,  5'd6,  32'hFFFF_FFFD,   LAT);
    run(OP_REM,  32'd7,          32'hFFFF_FFFE,  5'd7,  32'd1,           LAT);
    run(OP_REMU, 32'hFFFF_FFFF,  32'h10,         5'd8,  32'hF,           LAT);
    run(OP_DIVU, 32'hFFFF_FFFF,  32'h10,         5'd9,  32'h0FFF_FFFF,   LAT);
    // Divide-by-zero and signed overflow
    run(OP_DIVU, 32'd5,          32'd0,          5'd10, 32'hFFFF_FFFF,   SPL);
    run(OP_REMU, 32'd5,          32'd0,          5'd11, 32'd5,           SPL);
    run(OP_DIV,  32'hFFFF_FFEC,  32'd0,          5'd12, 32'hFFFF_FFFF,   SPL);
    run(OP_REM,  32'hFFFF_FFEC,  32'd0,          5'd13, 32'hFFFF_FFEC,   SPL);
    run(OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  5'd14, 32'h8000_0000,   SPL);
    run(OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  5'd15, 32'd0,           SPL);

    // Non-divide code is ignored
    in_valid = 1'b1; alu_select = 5'b00000; operand_a = 32'd9; operand_b = 32'd3;
    @(posedge clk); #1;
    alu_select = 5'b01100;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("ignore_non_div_busy", 32'(busy), 32'd0);

    // Flush together with in_valid in IDLE does not accept
    flush = 1'b1; in_valid = 1'b1; alu_select = OP_DIV; tag_in = 5'd16;
    #1;
    chk("in_ready_during_flush", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_with_valid_busy", 32'(busy), 32'd0);

    // Backpressure
    out_ready = 1'b0;
    issue(OP_DIV, 32'd100, 32'd7, 5'd17, 32'd14, LAT, 1'b1);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_valid_seen", 32'(out_valid), 32'd1);
    repeat (10) begin
      @(posedge clk); #1;
      chk("bp_in_ready_low", 32'(in_ready), 32'd0);
      chk("bp_valid_held", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_in_ready_after_hs", 32'(in_ready), 32'd1);
    chk("bp_valid_after_hs", 32'(out_valid), 32'd0);
    chk("bp_result_zero", result, 32'd0);
    wait_drain();

    // Flush at CALC count 10
    issue(OP_DIV, 32'd1000, 32'd3, 5'd21, 32'd0, LAT, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_valid", 32'(out_valid), 32'd0);
    repeat (40) @(posedge clk);
    #1;
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    run(OP_REM, 32'd1000, 32'd3, 5'd23, 32'd1, LAT);

    // Reset at CALC count 20
    issue(OP_DIVU, 32'd1000, 32'd7, 5'd22, 32'd0, LAT, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_result", result, 32'd0);
    chk("midrst_tag", 32'(tag_out), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    repeat (40) @(posedge clk);
    #1;
    run(OP_DIVU, 32'd1000, 32'd7, 5'd24, 32'd142, LAT);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
